// File: rtl/sgpr_file.sv
// Per-wavefront scalar register file with a 2-entry response buffer.
// Optional same-cycle write-to-read forwarding: SGPR_WR_BYPASS_EN.
module sgpr_file #(
  parameter int NUM_SGPR = 106,
  parameter int ADDR_W   = 7,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sgpr_rd_req_valid,
  output logic              sgpr_rd_req_ready,
  input  logic [ADDR_W-1:0] sgpr_rd_req_src0_addr,
  input  logic              sgpr_rd_req_src0_wide,
  input  logic [ADDR_W-1:0] sgpr_rd_req_src1_addr,
  input  logic              sgpr_rd_req_src1_wide,
  input  logic [TAG_W-1:0]  sgpr_rd_req_tag,
  output logic              sgpr_rd_resp_valid,
  input  logic              sgpr_rd_resp_ready,
  output logic [63:0]       sgpr_rd_resp_src0_data,
  output logic [63:0]       sgpr_rd_resp_src1_data,
  output logic [TAG_W-1:0]  sgpr_rd_resp_tag,
  input  logic              sgpr_wr_valid,
  input  logic [ADDR_W-1:0] sgpr_wr_addr,
  input  logic              sgpr_wr_wide,
  input  logic [63:0]       sgpr_wr_data,
  output logic              sgpr_oob
);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [63:0]      d0;
    logic [63:0]      d1;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_SGPR);

  logic [31:0] regs [NUM_SGPR];

  occ_t   state;
  entry_t e0, e1, rd_entry;
  logic   ready_q, oob_q;
  logic   accept, pop, rd_oob;
  addr_t  wr_lo, wr_hi;
  logic   wr_oob, wr_en;

  function automatic logic oob_chk(input addr_t a);
    return {1'b0, a} >= LIMIT;
  endfunction

  function automatic addr_t base_of(input addr_t a, input logic wide);
    return wide ? {a[ADDR_W-1:1], 1'b0} : a;
  endfunction

  // Caller guarantees a is in range.
  function automatic logic [31:0] rd_word(input addr_t a);
    logic [31:0] w;
    w = regs[a];
`ifdef SGPR_WR_BYPASS_EN
    if (wr_en && a == wr_lo)
      w = sgpr_wr_data[31:0];
    else if (wr_en && sgpr_wr_wide && a == wr_hi)
      w = sgpr_wr_data[63:32];
`endif
    return w;
  endfunction

  function automatic logic [63:0] operand(input addr_t a, input logic wide);
    addr_t b;
    logic [31:0] hi;
    b = base_of(a, wide);
    if (oob_chk(b))
      return 64'd0;
    hi = wide ? rd_word(b | addr_t'(1)) : 32'd0;
    return {hi, rd_word(b)};
  endfunction

  always_comb begin
    wr_lo  = base_of(sgpr_wr_addr, sgpr_wr_wide);
    wr_hi  = wr_lo | addr_t'(1);
    wr_oob = oob_chk(wr_lo);
    wr_en  = sgpr_wr_valid && !wr_oob;
  end

  always_comb begin
    rd_entry.d0  = operand(sgpr_rd_req_src0_addr, sgpr_rd_req_src0_wide);
    rd_entry.d1  = operand(sgpr_rd_req_src1_addr, sgpr_rd_req_src1_wide);
    rd_entry.tag = sgpr_rd_req_tag;
    rd_oob = oob_chk(base_of(sgpr_rd_req_src0_addr, sgpr_rd_req_src0_wide))
          || oob_chk(base_of(sgpr_rd_req_src1_addr, sgpr_rd_req_src1_wide));
  end

  assign accept = sgpr_rd_req_valid && ready_q;
  assign pop    = sgpr_rd_resp_valid && sgpr_rd_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      e0      <= '0;
      e1      <= '0;
      ready_q <= 1'b1;
      oob_q   <= 1'b0;
      for (int i = 0; i < NUM_SGPR; i++)
        regs[i] <= 32'd0;
    end else begin
      oob_q <= (accept && rd_oob) || (sgpr_wr_valid && wr_oob);
      if (wr_en) begin
        regs[wr_lo] <= sgpr_wr_data[31:0];
        if (sgpr_wr_wide)
          regs[wr_hi] <= sgpr_wr_data[63:32];
      end
      unique case (state)
        EMPTY: begin
          if (accept) begin
            e0    <= rd_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            e0 <= rd_entry;
          end else if (accept) begin
            e1      <= rd_entry;
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // Ready is low here, so only a pop can occur.
          if (pop) begin
            e0      <= e1;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign sgpr_rd_req_ready      = ready_q;
  assign sgpr_rd_resp_valid     = (state != EMPTY);
  assign sgpr_rd_resp_src0_data = e0.d0;
  assign sgpr_rd_resp_src1_data = e0.d1;
  assign sgpr_rd_resp_tag       = e0.tag;
  assign sgpr_oob               = oob_q;

endmodule

// File: tb/tb_sgpr_file.sv
// Randomized self-checking bench for sgpr_file.
// Reference model: word array plus response queue.
module tb_sgpr_file;

  localparam int N  = 106;
  localparam int AW = 7;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] s0a, s1a;
  logic          s0w, s1w;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_ready;
  logic [63:0]   d0, d1;
  logic [TW-1:0] resp_tag;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic          wr_wide;
  logic [63:0]   wr_data;
  logic          oob;

  sgpr_file #(.NUM_SGPR(N), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .sgpr_rd_req_valid     (req_valid),
    .sgpr_rd_req_ready     (req_ready),
    .sgpr_rd_req_src0_addr (s0a),
    .sgpr_rd_req_src0_wide (s0w),
    .sgpr_rd_req_src1_addr (s1a),
    .sgpr_rd_req_src1_wide (s1w),
    .sgpr_rd_req_tag       (req_tag),
    .sgpr_rd_resp_valid    (resp_valid),
    .sgpr_rd_resp_ready    (resp_ready),
    .sgpr_rd_resp_src0_data(d0),
    .sgpr_rd_resp_src1_data(d1),
    .sgpr_rd_resp_tag      (resp_tag),
    .sgpr_wr_valid         (wr_valid),
    .sgpr_wr_addr          (wr_addr),
    .sgpr_wr_wide          (wr_wide),
    .sgpr_wr_data          (wr_data),
    .sgpr_oob              (oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   d0;
    logic [63:0]   d1;
    logic [TW-1:0] tag;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mem [N];
  logic        exp_oob;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic int base_idx(input logic [AW-1:0] a, input logic w);
    int b;
    b = int'(a);
    if (w) b = (b / 2) * 2;
    return b;
  endfunction

  function automatic bit is_oob(input logic [AW-1:0] a, input logic w);
    return base_idx(a, w) >= N;
  endfunction

  function automatic logic [63:0] mread(input logic [AW-1:0] a, input logic w);
    int b;
    b = base_idx(a, w);
    if (b >= N) return 64'd0;
    if (w) return {mem[b+1], mem[b]};
    return {32'd0, mem[b]};
  endfunction

  function automatic void mwrite(input logic [AW-1:0] a, input logic w,
                                 input logic [63:0] d);
    int b;
    b = base_idx(a, w);
    if (b >= N) return;
    mem[b] = d[31:0];
    if (w) mem[b+1] = d[63:32];
  endfunction

  // Advance one clock; the model follows the same inputs.
  task automatic clk_step();
    resp_t r;
    bit acc, pp;
    if (rst) begin
      @(posedge clk);
      #1;
      q.delete();
      foreach (mem[i]) mem[i] = 32'd0;
      exp_oob = 1'b0;
      return;
    end
    acc = req_valid && (q.size() < 2);
    pp  = (q.size() > 0) && resp_ready;
    exp_oob = (acc && (is_oob(s0a, s0w) || is_oob(s1a, s1w)))
           || (wr_valid && is_oob(wr_addr, wr_wide));
`ifdef SGPR_WR_BYPASS_EN
    if (wr_valid) mwrite(wr_addr, wr_wide, wr_data);
`endif
    r.d0  = mread(s0a, s0w);
    r.d1  = mread(s1a, s1w);
    r.tag = req_tag;
`ifndef SGPR_WR_BYPASS_EN
    if (wr_valid) mwrite(wr_addr, wr_wide, wr_data);
`endif
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(r);
  endtask

  task automatic set_req(input logic v, input int a0, input logic w0,
                         input int a1, input logic w1, input int t);
    req_valid = v;
    s0a = AW'(a0); s0w = w0;
    s1a = AW'(a1); s1w = w1;
    req_tag = TW'(t);
  endtask

  task automatic set_wr(input logic v, input int a, input logic w,
                        input logic [63:0] d);
    wr_valid = v; wr_addr = AW'(a); wr_wide = w; wr_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_step();
    clk_step();
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", resp_valid); end
    n_cmp++; if (d0 !== 64'd0 || d1 !== 64'd0) begin n_err++; $display("FAIL rst_data got %h %h want 0", d0, d1); end
    n_cmp++; if (resp_tag !== 4'd0) begin n_err++; $display("FAIL rst_tag got %h want 0", resp_tag); end
    n_cmp++; if (oob !== 1'b0) begin n_err++; $display("FAIL rst_oob got %b want 0", oob); end
  endtask

  task automatic test_zero_read();
    resp_ready = 1'b1;
    set_req(1'b1, 5, 1'b0, 6, 1'b0, 3);
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL zr_valid got %b want 1", resp_valid); end
    n_cmp++; if (d0 !== 64'd0 || d1 !== 64'd0) begin n_err++; $display("FAIL zr_data got %h %h want 0", d0, d1); end
    n_cmp++; if (resp_tag !== 4'd3) begin n_err++; $display("FAIL zr_tag got %h want 3", resp_tag); end
    clk_step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL zr_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_wide();
    set_wr(1'b1, 10, 1'b1, 64'hDEADBEEF_01234567);
    clk_step();
    set_wr(1'b0, 0, 1'b0, 64'd0);
    set_req(1'b1, 10, 1'b1, 11, 1'b0, 7);
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (d0 !== 64'hDEADBEEF_01234567) begin n_err++; $display("FAIL wide_src0 got %h want deadbeef01234567", d0); end
    n_cmp++; if (d1 !== 64'h00000000_DEADBEEF) begin n_err++; $display("FAIL wide_src1 got %h want 00000000deadbeef", d1); end
    n_cmp++; if (resp_tag !== 4'd7) begin n_err++; $display("FAIL wide_tag got %h want 7", resp_tag); end
    clk_step();
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    set_req(1'b1, 10, 1'b1, 11, 1'b0, 0);
    clk_step();
    set_req(1'b1, 10, 1'b0, 11, 1'b1, 1);
    clk_step();
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", req_ready); end
    n_cmp++; if (resp_tag !== 4'd0) begin n_err++; $display("FAIL bp_head got %h want 0", resp_tag); end
    set_req(1'b1, 11, 1'b0, 10, 1'b1, 2);
    clk_step();
    clk_step();
    n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold got rdy=%b val=%b want 0 1", req_ready, resp_valid); end
    n_cmp++; if (resp_tag !== 4'd0 || d0 !== q[0].d0) begin n_err++; $display("FAIL bp_stable got %h %h want 0 %h", resp_tag, d0, q[0].d0); end
    resp_ready = 1'b1;
    clk_step();
    n_cmp++; if (resp_tag !== 4'd1 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop1 got tag=%h rdy=%b want 1 1", resp_tag, req_ready); end
    n_cmp++; if (d1 !== q[0].d1) begin n_err++; $display("FAIL bp_data1 got %h want %h", d1, q[0].d1); end
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (resp_tag !== 4'd2 || resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_pop2 got tag=%h val=%b want 2 1", resp_tag, resp_valid); end
    n_cmp++; if (d0 !== 64'h00000000_DEADBEEF) begin n_err++; $display("FAIL bp_data2 got %h want deadbeef", d0); end
    clk_step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", resp_valid); end
  endtask

  task automatic test_oob();
    set_req(1'b1, 106, 1'b0, 107, 1'b1, 9);
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (d0 !== 64'd0 || d1 !== 64'd0) begin n_err++; $display("FAIL oob_data got %h %h want 0", d0, d1); end
    n_cmp++; if (oob !== 1'b1) begin n_err++; $display("FAIL oob_pulse got %b want 1", oob); end
    clk_step();
    n_cmp++; if (oob !== 1'b0) begin n_err++; $display("FAIL oob_clear got %b want 0", oob); end
    set_wr(1'b1, 120, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    clk_step();
    set_wr(1'b0, 0, 1'b0, 64'd0);
    n_cmp++; if (oob !== 1'b1) begin n_err++; $display("FAIL oob_wr got %b want 1", oob); end
    for (int a = 0; a < N; a += 2) begin
      set_req(1'b1, a, 1'b1, a, 1'b1, a % 16);
      clk_step();
      n_cmp++; if (d0 !== q[0].d0) begin n_err++; $display("FAIL oob_keep[%0d] got %h want %h", a, d0, q[0].d0); end
    end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    clk_step();
  endtask

  task automatic test_bypass();
    logic [63:0] want;
`ifdef SGPR_WR_BYPASS_EN
    want = 64'h55;
`else
    want = 64'h0;
`endif
    set_wr(1'b1, 4, 1'b0, 64'h55);
    set_req(1'b1, 4, 1'b0, 5, 1'b0, 4);
    clk_step();
    set_wr(1'b0, 0, 1'b0, 64'd0);
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (d0 !== want) begin n_err++; $display("FAIL byp_src0 got %h want %h", d0, want); end
    set_req(1'b1, 4, 1'b0, 4, 1'b1, 5);
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (d0 !== 64'h55 || d1 !== 64'h55) begin n_err++; $display("FAIL byp_after got %h %h want 55 55", d0, d1); end
    clk_step();
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 127));
    return int'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_req($urandom_range(0, 1) == 1, rnd_addr(), 1'($urandom), rnd_addr(),
              1'($urandom), int'($urandom_range(0, 15)));
      set_wr($urandom_range(0, 1) == 1, rnd_addr(), 1'($urandom),
             {$urandom, $urandom});
      resp_ready = ($urandom_range(0, 3) != 0);
      clk_step();
      n_cmp++; if (req_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, q.size() < 2); end
      n_cmp++; if (resp_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, resp_valid, q.size() > 0); end
      n_cmp++; if (oob !== exp_oob) begin n_err++; $display("FAIL rnd_oob[%0d] got %b want %b", i, oob, exp_oob); end
      if (q.size() > 0) begin
        n_cmp++;
        if (d0 !== q[0].d0 || d1 !== q[0].d1 || resp_tag !== q[0].tag) begin
          n_err++;
          $display("FAIL rnd_resp[%0d] got %h %h %h want %h %h %h", i, d0, d1,
                   resp_tag, q[0].d0, q[0].d1, q[0].tag);
        end
      end
    end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    set_wr(1'b0, 0, 1'b0, 64'd0);
    resp_ready = 1'b1;
    clk_step();
    clk_step();
  endtask

  task automatic test_reset_mid();
    set_wr(1'b1, 10, 1'b1, 64'h1111_2222_3333_4444);
    clk_step();
    set_wr(1'b0, 0, 1'b0, 64'd0);
    resp_ready = 1'b0;
    set_req(1'b1, 10, 1'b1, 10, 1'b0, 5);
    clk_step();
    set_req(1'b1, 11, 1'b0, 10, 1'b1, 6);
    clk_step();
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rm_full got %b want 0", req_ready); end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready got %b want 1", req_ready); end
    resp_ready = 1'b1;
    set_req(1'b1, 10, 1'b1, 10, 1'b0, 1);
    clk_step();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (d0 !== 64'd0 || d1 !== 64'd0) begin n_err++; $display("FAIL rm_read got %h %h want 0", d0, d1); end
    clk_step();
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 0);
    set_wr(1'b0, 0, 1'b0, 64'd0);
    exp_oob = 1'b0;
    foreach (mem[i]) mem[i] = 32'd0;
    #1;
    test_reset();
    test_zero_read();
    test_wide();
    test_back_to_back();
    test_oob();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sgpr_file.md
Name: sgpr_file

Overview:
- Per-wavefront scalar general-purpose register file that sits directly downstream of the SALU issue stage.
- Serves the issue stage's SGPR operand read requests: two source operands per request, each 32-bit or 64-bit.
- Accepts writebacks from the SALU execute stage.
- Responses come back through a 2-entry output buffer with valid/ready handshaking, so issue-side backpressure never drops data.

Parameters:
- NUM_SGPR, 106, number of 32-bit scalar registers; must be even.
- ADDR_W, 7, SGPR address width; must satisfy 2**ADDR_W >= NUM_SGPR.
- TAG_W, 4, opaque request tag width, returned unchanged with the response.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sgpr_rd_req_valid  input  1  read request valid.
- sgpr_rd_req_ready  output  1  request accepted when valid && ready.
- sgpr_rd_req_src0_addr  input  ADDR_W  source 0 SGPR index.
- sgpr_rd_req_src0_wide  input  1  source 0 is 64-bit (register pair).
- sgpr_rd_req_src1_addr  input  ADDR_W  source 1 SGPR index.
- sgpr_rd_req_src1_wide  input  1  source 1 is 64-bit (register pair).
- sgpr_rd_req_tag  input  TAG_W  request tag.
- sgpr_rd_resp_valid  output  1  response valid.
- sgpr_rd_resp_ready  input  1  consumer ready.
- sgpr_rd_resp_src0_data  output  64  source 0 operand; upper 32 bits are zero when narrow.
- sgpr_rd_resp_src1_data  output  64  source 1 operand; upper 32 bits are zero when narrow.
- sgpr_rd_resp_tag  output  TAG_W  tag of the request this response answers.
- sgpr_wr_valid  input  1  writeback strobe; always accepted, no ready signal.
- sgpr_wr_addr  input  ADDR_W  writeback destination index.
- sgpr_wr_wide  input  1  64-bit writeback to a register pair.
- sgpr_wr_data  input  64  writeback data; upper 32 bits ignored when narrow.
- sgpr_oob  output  1  one-cycle pulse on any out-of-range read or write.

Behaviour:
- Reset: all SGPRs read 0; both buffer entries invalid; sgpr_rd_req_ready=1; sgpr_rd_resp_valid=0; resp data/tag=0; sgpr_oob=0.
- Reset mid-operation: a buffered response that has not been handed off is discarded.
- Storage: NUM_SGPR x 32 flops.
- Wide access: uses pair (a & ~1, (a & ~1)+1). Low word = even register, high word = odd register. An odd wide address is silently aligned down.
- Out of range (aligned base >= NUM_SGPR):
  - Reads return 0.
  - Writes are dropped.
  - sgpr_oob pulses for 1 cycle in the cycle after acceptance.
- Read latency: the register array is sampled in the accept cycle. The response is visible the next cycle; minimum request-to-response latency is 1 cycle.
- Output buffer: 2 entries in FIFO order, head drives the resp_* outputs.
  - sgpr_rd_req_ready = (count < 2). It is registered from the occupancy count only, with no combinational path from sgpr_rd_resp_ready.
  - Occupancy FSM states EMPTY(0), ONE(1), FULL(2):
    - Accept without pop: +1.
    - Pop without accept: -1.
    - Accept and pop in the same cycle: count unchanged; the new entry goes behind the remaining one.
  - With resp_ready held at 1: one response per cycle, no bubbles.
  - With resp_ready=0: the resp_* outputs must hold stable while resp_valid=1.
- Writes: take effect at the clock edge.
  - A narrow write updates one register.
  - A wide write updates the pair.
  - A read accepted in the cycle after a write sees the new value.
- Same-cycle write and read to the same register: governed by the optional feature.
- Both sources may name the same register or overlapping pairs; each returns the full value independently.

Optional Feature:
- Macro: SGPR_WR_BYPASS_EN.
- Defined: a read accepted in the same cycle as an in-range write to an overlapping register returns the write data. Forwarding is per 32-bit word, so a partial overlap forwards only the overlapping word.
- Undefined: that read returns the pre-write value, and the issue stage is responsible for the 1-cycle hazard stall.

Test Plan:
- Reset, then read src0=5 narrow, src1=6 narrow with tag=3 → next cycle resp_valid=1, both data=0, tag=3.
- Write addr=10 wide data=0xDEADBEEF_01234567, next cycle read src0=10 wide and src1=11 narrow → src0=0xDEADBEEF01234567, src1=0x00000000DEADBEEF.
- Hold resp_ready=0 and issue 3 back-to-back requests → req_ready drops after the 2nd acceptance; the 3rd waits. Raise resp_ready → responses come out in order with tags 0,1,2 and no loss or duplication.
- Read src0=106 narrow and src1=107 wide (NUM_SGPR=106) → both data=0 and sgpr_oob pulses once. A write to addr=120 leaves all registers unchanged.
- Same-cycle write addr=4 data=0x55 with read src0=4 → response 0x55 when SGPR_WR_BYPASS_EN is defined, 0 when not defined.
- Assert rst with 2 entries buffered → next cycle resp_valid=0, req_ready=1, and a read of addr=10 returns 0.
